// File: rtl/pixel_pkg.sv
// Shared pixel-stream types: token format and encoder state, common to the
// run-length encoder and the repeat expander.
package pixel_pkg;

  localparam int VALUE_W = 6;
  localparam int COUNT_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } rle_enc_state_t;

  typedef struct packed {
    logic [VALUE_W-1:0] value;
    logic [COUNT_W-1:0] count;
    logic               last;
  } rle_token_t;

endpackage

// File: rtl/rle_token_slot.sv
// Single-entry token register with valid/ready output; a load always wins over
// a drain, so the producer must only load when free is high.
module rle_token_slot
  import pixel_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  rle_token_t load_tok,
  input  logic       out_ready,
  output logic       out_valid,
  output rle_token_t out_tok,
  output logic       free
);

  assign free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_tok   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_tok   <= load_tok;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_rle_encoder.sv
// Run-length encoder: collapses consecutive equal pixels into (value, count, last)
// tokens, count in 1..MAX_RUN, one pixel per cycle when the consumer keeps up.
module pixel_rle_encoder #(
  parameter int VALUE_W = pixel_pkg::VALUE_W,
  parameter int COUNT_W = pixel_pkg::COUNT_W,
  parameter int MAX_RUN = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VALUE_W-1:0] in_value,
  input  logic               in_last,
  output logic               tok_valid,
  input  logic               tok_ready,
  output logic [VALUE_W-1:0] tok_value,
  output logic [COUNT_W-1:0] tok_count,
  output logic               tok_last
);
  import pixel_pkg::*;

  localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_RUN);
  localparam logic [COUNT_W-1:0] ONE     = COUNT_W'(1);

  rle_enc_state_t     state;
  logic [VALUE_W-1:0] run_value;
  logic [COUNT_W-1:0] run_count;

  logic       slot_free;
  logic       accept;
  logic       match;
  logic       emit;
  rle_token_t emit_tok;
  rle_token_t tok;

  assign in_ready = rst_n && (state != FLUSH) && slot_free;
  assign accept   = in_valid && in_ready;
  // A full run refuses an equal pixel, so the increment below can never wrap.
  assign match    = (in_value == run_value) && (run_count < MAX_CNT);

  always_comb begin
    emit     = 1'b0;
    emit_tok = '0;
    case (state)
      IDLE: begin
        if (accept && in_last) begin
          emit     = 1'b1;
          emit_tok = '{value: in_value, count: ONE, last: 1'b1};
        end
      end
      RUN: begin
        if (accept) begin
          if (match && in_last) begin
            emit     = 1'b1;
            emit_tok = '{value: run_value, count: run_count + ONE, last: 1'b1};
          end else if (!match) begin
            emit     = 1'b1;
            emit_tok = '{value: run_value, count: run_count, last: 1'b0};
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          emit     = 1'b1;
          emit_tok = '{value: run_value, count: ONE, last: 1'b1};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_value <= '0;
      run_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !in_last) begin
            run_value <= in_value;
            run_count <= ONE;
            state     <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (match) begin
              if (in_last) begin
                run_count <= '0;
                state     <= IDLE;
              end else begin
                run_count <= run_count + ONE;
              end
            end else begin
              // Differing last pixel is owed as its own count-1 token next cycle.
              run_value <= in_value;
              run_count <= ONE;
              state     <= in_last ? FLUSH : RUN;
            end
          end
        end
        FLUSH: begin
          if (slot_free) begin
            run_count <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rle_token_slot u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (emit),
    .load_tok  (emit_tok),
    .out_ready (tok_ready),
    .out_valid (tok_valid),
    .out_tok   (tok),
    .free      (slot_free)
  );

  assign tok_value = tok.value;
  assign tok_count = tok.count;
  assign tok_last  = tok.last;

endmodule

// File: tb/tb_pixel_rle_encoder.sv
// Directed bench for pixel_rle_encoder: hand-computed token lists per scenario.
module tb_pixel_rle_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_value;
  logic       in_last;
  logic       tok_valid;
  logic       tok_ready;
  logic [5:0] tok_value;
  logic [9:0] tok_count;
  logic       tok_last;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [16:0] q [$];

  pixel_rle_encoder #(.VALUE_W(6), .COUNT_W(10), .MAX_RUN(1023)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_last   (in_last),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_value (tok_value),
    .tok_count (tok_count),
    .tok_last  (tok_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Token handshakes complete at the following posedge; inputs are stable here.
  always @(negedge clk)
    if (rst_n && tok_valid && tok_ready) q.push_back({tok_value, tok_count, tok_last});

  function automatic logic [16:0] mk(input logic [5:0] v, input int c, input logic l);
    return {v, 10'(c), l};
  endfunction

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic push_pix(input logic [5:0] v, input logic l);
    int n = 0;
    in_valid = 1'b1; in_value = v; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout value=%h in_ready stuck low", v);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_tokens(input int n);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (q.size() >= n) break;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tok_ready = 1'b1; in_valid = 1'b0; in_value = '0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_checks++; if (tok_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tok_valid got %b want 0", tok_valid); end
    n_checks++;
    if ({tok_value, tok_count, tok_last} !== 17'h0) begin
      n_fail++; $display("FAIL rst_tok got %h want 0", {tok_value, tok_count, tok_last});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_flush();
    logic [16:0] exp [$];
    q.delete();
    push_pix(6'd5, 1'b0); push_pix(6'd5, 1'b0); push_pix(6'd5, 1'b0); push_pix(6'd9, 1'b1);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_low got %b want 0", in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_back got %b want 1", in_ready); end
    @(posedge clk); #1;
    wait_tokens(2);
    exp.push_back(mk(6'd5, 3, 1'b0)); exp.push_back(mk(6'd9, 1, 1'b1));
    n_checks++; if (q.size() != exp.size()) begin n_fail++; $display("FAIL basic_count got %0d want %0d", q.size(), exp.size()); end
    foreach (exp[i]) begin
      n_checks++;
      if (i >= q.size() || q[i] !== exp[i]) begin n_fail++; $display("FAIL basic_tok[%0d] got %h want %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [16:0] exp [$];
    q.delete();
    for (int i = 0; i < 1025; i++) push_pix(6'h2A, i == 1024);
    wait_tokens(2);
    exp.push_back(mk(6'h2A, 1023, 1'b0)); exp.push_back(mk(6'h2A, 2, 1'b1));
    n_checks++; if (q.size() != exp.size()) begin n_fail++; $display("FAIL sat_count got %0d want %0d", q.size(), exp.size()); end
    foreach (exp[i]) begin
      n_checks++;
      if (i >= q.size() || q[i] !== exp[i]) begin n_fail++; $display("FAIL sat_tok[%0d] got %h want %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_single();
    logic [16:0] exp [$];
    q.delete();
    push_pix(6'h11, 1'b1);
    @(negedge clk);
    n_checks++; if (tok_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", tok_valid); end
    n_checks++;
    if ({tok_value, tok_count, tok_last} !== mk(6'h11, 1, 1'b1)) begin
      n_fail++; $display("FAIL single_tok got %h want %h", {tok_value, tok_count, tok_last}, mk(6'h11, 1, 1'b1));
    end
    @(posedge clk); #1;
    push_pix(6'h11, 1'b1);
    wait_tokens(2);
    exp.push_back(mk(6'h11, 1, 1'b1)); exp.push_back(mk(6'h11, 1, 1'b1));
    n_checks++; if (q.size() != exp.size()) begin n_fail++; $display("FAIL single_count got %0d want %0d", q.size(), exp.size()); end
    foreach (exp[i]) begin
      n_checks++;
      if (i >= q.size() || q[i] !== exp[i]) begin n_fail++; $display("FAIL single_tok[%0d] got %h want %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp [$];
    q.delete();
    push_pix(6'd1, 1'b0); push_pix(6'd1, 1'b0); push_pix(6'd2, 1'b0);
    tok_ready = 1'b0;
    in_valid = 1'b1; in_value = 6'd2; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      n_checks++;
      if ({tok_valid, tok_value, tok_count, tok_last} !== {1'b1, mk(6'd1, 2, 1'b0)}) begin
        n_fail++; $display("FAIL bp_hold[%0d] got %h want %h", i, {tok_valid, tok_value, tok_count, tok_last}, {1'b1, mk(6'd1, 2, 1'b0)});
      end
      @(posedge clk); #1;
    end
    tok_ready = 1'b1;
    push_pix(6'd2, 1'b0); push_pix(6'd3, 1'b1);
    wait_tokens(3);
    exp.push_back(mk(6'd1, 2, 1'b0)); exp.push_back(mk(6'd2, 2, 1'b0)); exp.push_back(mk(6'd3, 1, 1'b1));
    n_checks++; if (q.size() != exp.size()) begin n_fail++; $display("FAIL bp_count got %0d want %0d", q.size(), exp.size()); end
    foreach (exp[i]) begin
      n_checks++;
      if (i >= q.size() || q[i] !== exp[i]) begin n_fail++; $display("FAIL bp_tok[%0d] got %h want %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_mid_reset();
    logic [16:0] exp [$];
    q.delete();
    for (int i = 0; i < 4; i++) push_pix(6'd7, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (tok_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_tok_valid got %b want 0", tok_valid); end
    @(posedge clk); #1;
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL mrst_no_token got %0d want 0", q.size()); end
    push_pix(6'd7, 1'b1);
    wait_tokens(1);
    exp.push_back(mk(6'd7, 1, 1'b1));
    n_checks++; if (q.size() != exp.size()) begin n_fail++; $display("FAIL mrst_count got %0d want %0d", q.size(), exp.size()); end
    foreach (exp[i]) begin
      n_checks++;
      if (i >= q.size() || q[i] !== exp[i]) begin n_fail++; $display("FAIL mrst_tok[%0d] got %h want %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp [$];
    int c0;
    q.delete();
    c0 = cyc;
    push_pix(6'd1, 1'b0); push_pix(6'd2, 1'b0); push_pix(6'd1, 1'b0); push_pix(6'd2, 1'b1);
    n_checks++; if (cyc - c0 != 4) begin n_fail++; $display("FAIL b2b_cycles got %0d want 4", cyc - c0); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_flush_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    wait_tokens(4);
    exp.push_back(mk(6'd1, 1, 1'b0)); exp.push_back(mk(6'd2, 1, 1'b0));
    exp.push_back(mk(6'd1, 1, 1'b0)); exp.push_back(mk(6'd2, 1, 1'b1));
    n_checks++; if (q.size() != exp.size()) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", q.size(), exp.size()); end
    foreach (exp[i]) begin
      n_checks++;
      if (i >= q.size() || q[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_tok[%0d] got %h want %h", i, q[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_flush();
    test_saturation();
    test_single();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
